matrix_host_ctrl: RTL

- Host-side initiator for the matrix ALU.
- Accepts a command over a valid/ready channel, then byte-streams matrix A (and B for binary ops) in, packing elements into A_flat/B_flat.
- Drives the ALU opcode and scalar, waits for done, captures C_flat and overflow_flag, then streams the result matrix back out byte by byte.
- Sits between the host bus/UART bridge and the alu module.

---
 rtl/matrix_host_ctrl_if.sv | 41 ++++
 rtl/matrix_host_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_host_ctrl_if.sv
// Host-side channel bundle for matrix_host_ctrl: command, input byte stream, result byte stream.
// master = host/bridge side, slave = controller side.
// Signals: cmd_valid/cmd_ready/cmd_opcode/cmd_scalar/cmd_size, in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data/out_last/out_ovf.
interface matrix_host_ctrl_if #(
  parameter int ELEM_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic [7:0]        cmd_scalar;
  logic [2:0]        cmd_size;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_last;
  logic              out_ovf;

  modport master (
    output cmd_valid, cmd_opcode, cmd_scalar, cmd_size,
    input  cmd_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_last, out_ovf,
    output out_ready
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_scalar, cmd_size,
    output cmd_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_last, out_ovf,
    input  out_ready
  );
endinterface

// File: rtl/matrix_host_ctrl.sv
// Purpose: host-side initiator for the matrix ALU; loads A (and B), fires the ALU, drains C byte-wise.
// Latency: cmd->LOAD_A 1 cycle, last input byte->EXEC 1, EXEC->WAIT 1, done->first out_valid 1.
// Backpressure: in_ready only in LOAD states; out_data held stable while out_ready is low.
// Ports: clock/reset_n (sync active-low); host (slave modport: cmd/in/out channels);
//        busy, err (one-cycle abort pulse); A_flat/B_flat/f/opcode to ALU; C_flat/overflow_flag/done from ALU.
// Optional: define MATRIX_HOST_TIMEOUT_EN to abort WAIT after TIMEOUT cycles without done.
module matrix_host_ctrl #(
  parameter int ELEM_W  = 8,
  parameter int DIM     = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  matrix_host_ctrl_if.slave         host,
  output logic                      busy,
  output logic                      err,
  output logic [DIM*DIM*ELEM_W-1:0] A_flat,
  output logic [DIM*DIM*ELEM_W-1:0] B_flat,
  output logic [7:0]                f,
  output logic [2:0]                opcode,
  input  logic [DIM*DIM*ELEM_W-1:0] C_flat,
  input  logic                      overflow_flag,
  input  logic                      done
);

  localparam int FW = DIM * DIM * ELEM_W;
  localparam int IW = $clog2(FW);

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_SCALAR = 3'b110;
  localparam logic [2:0] OP_DET    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [7:0]    scalar_q;
  logic [2:0]    n_q;
  logic [2:0]    row, col;
  logic [2:0]    row_adv, col_adv;
  logic [FW-1:0] c_q;
  logic          ovf_q;
  logic          err_q;

  logic          cmd_fire, in_fire, out_fire;
  logic          at_end, out_end, is_binary, tmo_hit;
  logic [2:0]    n_cmd, n_last;
  logic [IW-1:0] base;

  // Handshakes are decoded from state directly so they never depend on the
  // ready outputs produced in the combinational process below.
  assign cmd_fire  = host.cmd_valid && (state == S_IDLE);
  assign in_fire   = host.in_valid && ((state == S_LOAD_A) || (state == S_LOAD_B));
  assign out_fire  = host.out_ready && (state == S_DRAIN);

  // Sizes outside 1..DIM fall back to the full matrix.
  assign n_cmd     = ((host.cmd_size == 3'd0) || (int'(host.cmd_size) > DIM)) ? 3'(DIM) : host.cmd_size;
  assign n_last    = n_q - 3'd1;
  assign is_binary = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b011);
  assign at_end    = (row == n_last) && (col == n_last);
  // Determinant results are a single element, so the first byte is also the last.
  assign out_end   = (op_q == OP_DET) || at_end;
  assign base      = IW'((int'(row) * DIM + int'(col)) * ELEM_W);

  // Row-major walk over the active n x n window; wraps to (0,0) after the last element.
  always_comb begin
    row_adv = row;
    col_adv = col + 3'd1;
    if (at_end) begin
      row_adv = 3'd0;
      col_adv = 3'd0;
    end else if (col == n_last) begin
      row_adv = row + 3'd1;
      col_adv = 3'd0;
    end
  end

`ifdef MATRIX_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    host.cmd_ready = 1'b0;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    host.out_data  = '0;
    host.out_last  = 1'b0;
    host.out_ovf   = 1'b0;
    busy           = (state != S_IDLE);
    opcode         = OP_NONE;
    f              = 8'd0;
    err            = err_q;

    case (state)
      S_IDLE: begin
        host.cmd_ready = 1'b1;
        if (cmd_fire && (host.cmd_opcode != OP_NONE)) state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        host.in_ready = 1'b1;
        if (in_fire && at_end) state_nxt = is_binary ? S_LOAD_B : S_EXEC;
      end
      S_LOAD_B: begin
        host.in_ready = 1'b1;
        if (in_fire && at_end) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        opcode    = op_q;
        f         = (op_q == OP_SCALAR) ? scalar_q : 8'd0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        opcode = op_q;
        f      = (op_q == OP_SCALAR) ? scalar_q : 8'd0;
        if (done)         state_nxt = S_DRAIN;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        host.out_valid = 1'b1;
        host.out_data  = c_q[base +: ELEM_W];
        host.out_last  = out_end;
        host.out_ovf   = ovf_q;
        if (out_fire && out_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= OP_NONE;
      scalar_q <= 8'd0;
      n_q      <= 3'd0;
      row      <= 3'd0;
      col      <= 3'd0;
      A_flat   <= '0;
      B_flat   <= '0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef MATRIX_HOST_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      state <= state_nxt;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            op_q     <= host.cmd_opcode;
            scalar_q <= host.cmd_scalar;
            n_q      <= n_cmd;
            row      <= 3'd0;
            col      <= 3'd0;
            A_flat   <= '0;
            B_flat   <= '0;
            ovf_q    <= 1'b0;
            if (host.cmd_opcode == OP_NONE) err_q <= 1'b1;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_fire) begin
            if (state == S_LOAD_A) A_flat[base +: ELEM_W] <= host.in_data;
            else                   B_flat[base +: ELEM_W] <= host.in_data;
            row <= row_adv;
            col <= col_adv;
          end
        end
`ifdef MATRIX_HOST_TIMEOUT_EN
        S_EXEC: tmo_cnt <= '0;
`endif
        S_WAIT: begin
          if (done) begin
            c_q   <= C_flat;
            ovf_q <= overflow_flag;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
`ifdef MATRIX_HOST_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (out_end) begin
              row <= 3'd0;
              col <= 3'd0;
            end else begin
              row <= row_adv;
              col <= col_adv;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
